// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: funct3 codes, memory-stage state encoding and
// the sizing helper for the memory-stage ack timeout counter.
package cpu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ma_state_t;

    // Counter must be able to hold the TIMEOUT value itself.
    function automatic int tmo_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Load/store lane formatting and legality check for RV32I accesses.
// Purely combinational, zero latency, no flow control.
module mem_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic        bad
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        misalign;
    logic        bad_f3;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        strb     = 4'b1111;
        wdata    = store_data;
        misalign = 1'b0;
        bad_f3   = 1'b0;
        load_val = 32'h0;

        case (funct3[1:0])
            2'b01:   misalign = addr_lo[0];
            2'b10:   misalign = |addr_lo;
            default: misalign = 1'b0;
        endcase

        if (is_load) begin
            bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end

        if (is_store) begin
            bad_f3 = funct3[2] | (&funct3[1:0]);
            case (funct3[1:0])
                2'b00: begin
                    strb  = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    strb  = 4'b0011 << addr_lo;
                    wdata = {2{store_data[15:0]}};
                end
                default: begin
                    strb  = 4'b1111;
                    wdata = store_data;
                end
            endcase
        end

        // Asking for both a load and a store is never meaningful.
        bad = (is_load | is_store) & ((is_load & is_store) | bad_f3 | misalign);

        case (funct3)
            F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            F3_LW:   load_val = rdata;
            F3_LBU:  load_val = {24'h0, byte_sel};
            F3_LHU:  load_val = {16'h0, half_sel};
            default: load_val = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32I MEM stage: captures E_*, runs one bus transfer per load/store, forwards to mem_rdwb.
// Latency 1 cycle for non-memory ops, >=1 extra per transfer; MEM_STALL holds upstream while busy.
module mem_access
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_INST,
    input  logic        E_VALID,
    input  logic [4:0]  E_REG_D,
    input  logic [31:0] E_REG_D_V,
    input  logic        E_MEM_RD,
    input  logic        E_MEM_WR,
    input  logic [2:0]  E_FUNCT3,
    input  logic [31:0] E_MEM_ADDR,
    input  logic [31:0] E_STORE_DATA,
    output logic        MEM_STALL,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_STRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic [31:0] A_PC,
    output logic [31:0] A_INST,
    output logic        A_VALID,
    output logic [4:0]  A_REG_D,
    output logic [31:0] A_REG_D_V,
    output logic        ERR,
    output logic [31:0] ERR_PC
);

    localparam int            CW       = tmo_cnt_w(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    ma_state_t      state;
    logic [CW-1:0]  tmo_cnt;
    logic [2:0]     f3_r;
    logic [1:0]     addr_lo_r;
    logic           ld_r;

    logic           busy;
    logic           mem_op;
    logic [2:0]     al_f3;
    logic [1:0]     al_addr_lo;
    logic [3:0]     al_strb;
    logic [31:0]    al_wdata;
    logic [31:0]    al_load_val;
    logic           al_bad;

    assign busy      = (state == ST_BUSY);
    assign mem_op    = E_VALID & (E_MEM_RD | E_MEM_WR);
    assign MEM_STALL = STALL | busy;

    // While busy the aligner formats the returning word using the captured access.
    assign al_f3      = busy ? f3_r      : E_FUNCT3;
    assign al_addr_lo = busy ? addr_lo_r : E_MEM_ADDR[1:0];

    mem_align u_align (
        .funct3     (al_f3),
        .is_load    (E_MEM_RD),
        .is_store   (E_MEM_WR),
        .addr_lo    (al_addr_lo),
        .store_data (E_STORE_DATA),
        .rdata      (MEM_RDATA),
        .strb       (al_strb),
        .wdata      (al_wdata),
        .load_val   (al_load_val),
        .bad        (al_bad)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            f3_r      <= 3'b000;
            addr_lo_r <= 2'b00;
            ld_r      <= 1'b0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= 32'h0;
            MEM_STRB  <= 4'h0;
            MEM_WDATA <= 32'h0;
            A_PC      <= 32'h0;
            A_INST    <= 32'h0;
            A_VALID   <= 1'b0;
            A_REG_D   <= 5'h0;
            A_REG_D_V <= 32'h0;
            ERR       <= 1'b0;
            ERR_PC    <= 32'h0;
        end else begin
            ERR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!STALL) begin
                        A_PC      <= E_PC;
                        A_INST    <= E_INST;
                        A_REG_D   <= E_REG_D;
                        A_REG_D_V <= E_REG_D_V;
                        f3_r      <= E_FUNCT3;
                        addr_lo_r <= E_MEM_ADDR[1:0];
                        ld_r      <= E_MEM_RD;
                        tmo_cnt   <= '0;
                        if (mem_op && al_bad) begin
                            A_VALID <= 1'b0;
                            ERR     <= 1'b1;
                            ERR_PC  <= E_PC;
                        end else if (mem_op) begin
                            A_VALID   <= 1'b0;
                            state     <= ST_BUSY;
                            MEM_REQ   <= 1'b1;
                            MEM_WE    <= E_MEM_WR;
                            MEM_ADDR  <= {E_MEM_ADDR[31:2], 2'b00};
                            MEM_STRB  <= al_strb;
                            MEM_WDATA <= E_MEM_WR ? al_wdata : 32'h0;
                        end else begin
                            A_VALID <= E_VALID;
                        end
                    end
                end
                ST_BUSY: begin
                    // Completion takes priority over a timeout expiring in the same cycle.
                    if (MEM_ACK) begin
                        MEM_REQ <= 1'b0;
                        state   <= ST_IDLE;
                        A_VALID <= 1'b1;
                        if (ld_r) begin
                            A_REG_D_V <= al_load_val;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        MEM_REQ <= 1'b0;
                        state   <= ST_IDLE;
                        A_VALID <= 1'b0;
                        ERR     <= 1'b1;
                        ERR_PC  <= A_PC;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
